// File: rtl/piradip_bitsched_pkg.sv
// piradip_bitsched_pkg: shared state encoding and counter widths for the bit frame scheduler.
package piradip_bitsched_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;
    localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/piradip_bit_stream.sv
// piradip_bit_stream: single-bit valid/ready stream with frame delimiter.
interface piradip_bit_stream;
    logic tvalid;
    logic tdata;
    logic tlast;
    logic tready;
    modport MANAGER (output tvalid, output tdata, output tlast, input tready);
    modport SUBORDINATE (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/piradip_rr_arbiter.sv
// piradip_rr_arbiter: combinational round-robin pick starting just after last_grant_i.
module piradip_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_grant_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);
    localparam int IW = $clog2(N_REQ);
    logic [IW-1:0] c;
    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        c       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            c = IW'((int'(last_grant_i) + k) % N_REQ);
            if (req_i[c]) begin
                grant_o    = '0;
                grant_o[c] = 1'b1;
                idx_o      = c;
            end
        end
    end
endmodule

// File: rtl/piradip_bit_frame_scheduler.sv
// piradip_bit_frame_scheduler: round-robin word requesters serialised MSB-first
// into framed bit stream with configurable length and inter-frame gap.
module piradip_bit_frame_scheduler
    import piradip_bitsched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int GAP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(WIDTH+1)-1:0] cfg_nbits,
    input  logic [GAP_W-1:0]           cfg_gap,
    input  logic [N_REQ-1:0]           req_tvalid,
    input  logic [N_REQ*WIDTH-1:0]     req_tdata,
    output logic [N_REQ-1:0]           req_tready,
    piradip_bit_stream.MANAGER         bits_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [FRAME_CNT_W-1:0]     frame_count
);
    localparam int NB_W = $clog2(WIDTH + 1);
    localparam int IW   = $clog2(N_REQ);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [NB_W-1:0]        cnt_q, cnt_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [IW-1:0]          last_q, last_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [FRAME_CNT_W-1:0] fc_q, fc_d;

    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic [NB_W-1:0]  n_sel;
    logic [WIDTH-1:0] word_sel;
    logic             shifting;
    logic             fire;

    piradip_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i        (req_tvalid),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .idx_o        (arb_idx)
    );

    assign n_sel    = (cfg_nbits == '0 || cfg_nbits > NB_W'(WIDTH)) ? NB_W'(WIDTH) : cfg_nbits;
    assign word_sel = req_tdata[arb_idx*WIDTH +: WIDTH];
    assign shifting = state_q == ST_SHIFT;
    assign fire     = shifting && bits_out.tready;

    // Word is pre-aligned so bit n-1 sits in the MSB; shifting left then streams it out.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        last_d  = last_q;
        grant_d = grant_q;
        fc_d    = fc_q;
        case (state_q)
            ST_IDLE: if (|req_tvalid) begin
                state_d = ST_SHIFT;
                shift_d = word_sel << (WIDTH - int'(n_sel));
                cnt_d   = n_sel;
                gap_d   = cfg_gap;
                last_d  = arb_idx;
                grant_d = arb_idx;
            end
            ST_SHIFT: if (fire) begin
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == NB_W'(1)) begin
                    fc_d    = fc_q + 1'b1;
                    state_d = (gap_q != '0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_d   = gap_q - 1'b1;
                state_d = (gap_q > GAP_W'(1)) ? ST_GAP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            grant_q <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            fc_q    <= fc_d;
        end
    end

    assign req_tready      = (state_q == ST_IDLE) ? arb_grant : '0;
    assign bits_out.tvalid = shifting;
    assign bits_out.tdata  = shifting & shift_q[WIDTH-1];
    assign bits_out.tlast  = shifting && cnt_q == NB_W'(1);
    assign grant_id        = grant_q;
    assign busy            = state_q != ST_IDLE;
    assign frame_count     = fc_q;
endmodule

// File: tb/tb_piradip_bit_frame_scheduler.sv
// tb_piradip_bit_frame_scheduler: directed checks of framing, arbitration, stalls, gaps and reset.
module tb_piradip_bit_frame_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   cfg_nbits;
    logic [7:0]   cfg_gap;
    logic [3:0]   req_tvalid;
    logic [127:0] req_tdata;
    logic [3:0]   req_tready;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  frame_count;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  wd [4];
    int           lows;

    piradip_bit_stream bs ();

    piradip_bit_frame_scheduler #(.N_REQ(4), .WIDTH(32), .GAP_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_nbits   (cfg_nbits),
        .cfg_gap     (cfg_gap),
        .req_tvalid  (req_tvalid),
        .req_tdata   (req_tdata),
        .req_tready  (req_tready),
        .bits_out    (bs),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first SHIFT cycle; consumes n bits, optionally stalling 1,0,0,1,...
    task automatic recv(input string tag, input logic [31:0] w, input int n, input bit stall);
        int got = 0;
        int c = 0;
        logic [31:0] acc = '0;
        while (got < n && c < 400) begin
            bs.tready = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            #1;
            chk({tag, "_tvalid"}, 32'(bs.tvalid), 32'd1);
            chk({tag, "_tdata"}, 32'(bs.tdata), 32'(w[n-1-got]));
            chk({tag, "_tlast"}, 32'(bs.tlast), 32'(got == n - 1));
            if (bs.tvalid && bs.tready) begin
                acc = {acc[30:0], bs.tdata};
                got++;
            end
            c++;
            tick();
        end
        bs.tready = 1'b1;
        chk({tag, "_nbits"}, 32'(got), 32'(n));
        chk({tag, "_word"}, acc, (n == 32) ? w : (w & ((32'h1 << n) - 32'h1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_nbits = 6'd8; cfg_gap = 8'd0; req_tvalid = '0; req_tdata = '0; bs.tready = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_tvalid", 32'(bs.tvalid), 32'd0);
        chk("rst_tdata", 32'(bs.tdata), 32'd0);
        chk("rst_tlast", 32'(bs.tlast), 32'd0);
        chk("rst_ready", 32'(req_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        rst = 1'b0;

        // Single 8-bit frame 0xA5 from requester 0.
        req_tdata[31:0] = 32'hA5; req_tvalid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_tready), 32'h1);
        tick();
        req_tvalid = '0;
        recv("t1", 32'hA5, 8, 1'b0);
        #1;
        chk("t1_count", 32'(frame_count), 32'd1);
        chk("t1_idle", 32'(bs.tvalid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // All requesters valid, 4-bit frames: grants 0,1,2,3,0 with one idle cycle each.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wd[0] = 32'hFFFF_FF03; wd[1] = 32'h1234_5605; wd[2] = 32'hABCD_EF09; wd[3] = 32'h0000_000C;
        for (int i = 0; i < 4; i++) req_tdata[i*32 +: 32] = wd[i];
        cfg_nbits = 6'd4; req_tvalid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            #1;
            chk("t2_ready", 32'(req_tready), 32'(1 << (f % 4)));
            tick();
            chk("t2_grant", 32'(grant_id), 32'(f % 4));
            chk("t2_busy", 32'(busy), 32'd1);
            recv("t2", wd[f%4], 4, 1'b0);
            #1;
            chk("t2_idle", 32'(bs.tvalid), 32'd0);
        end
        req_tvalid = '0;
        chk("t2_count", 32'(frame_count), 32'd5);

        // 32-bit frame (cfg_nbits=0) under 1,0,0,1 backpressure from requester 2.
        tick();
        req_tdata[95:64] = 32'hDEAD_BEEF; cfg_nbits = 6'd0; req_tvalid = 4'b0100;
        #1;
        chk("t3_ready", 32'(req_tready), 32'h4);
        tick();
        req_tvalid = '0;
        recv("t3", 32'hDEAD_BEEF, 32, 1'b1);
        #1;
        chk("t3_count", 32'(frame_count), 32'd6);
        chk("t3_grant", 32'(grant_id), 32'd2);

        // Gap of 3, config changed mid-frame, requester 1 back-to-back.
        tick();
        req_tdata[63:32] = 32'h0000_005A; cfg_nbits = 6'd8; cfg_gap = 8'd3; req_tvalid = 4'b0010;
        #1;
        chk("t4_ready", 32'(req_tready), 32'h2);
        tick();
        cfg_nbits = 6'd4; cfg_gap = 8'd0;
        recv("t4a", 32'h5A, 8, 1'b0);
        cfg_nbits = 6'd8; cfg_gap = 8'd3;
        lows = 0;
        #1;
        while (!bs.tvalid && lows < 20) begin
            if (lows == 0) chk("t4_gap_busy", 32'(busy), 32'd1);
            lows++;
            tick();
            #1;
        end
        chk("t4_low_cycles", 32'(lows), 32'd4);
        req_tvalid = '0;
        recv("t4b", 32'h5A, 8, 1'b0);
        chk("t4_grant", 32'(grant_id), 32'd1);
        chk("t4_count", 32'(frame_count), 32'd8);
        repeat (4) tick();

        // Reset after 5 bits of a 16-bit frame, then a 1-bit frame from requester 0.
        req_tdata[127:96] = 32'h0000_1234; cfg_nbits = 6'd16; cfg_gap = 8'd0; req_tvalid = 4'b1000;
        #1;
        chk("t5_ready", 32'(req_tready), 32'h8);
        tick();
        req_tvalid = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_bit", 32'(bs.tdata), 32'((32'h1234 >> (15 - i)) & 32'h1));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_rst_tvalid", 32'(bs.tvalid), 32'd0);
        chk("t5_rst_tlast", 32'(bs.tlast), 32'd0);
        chk("t5_rst_count", 32'(frame_count), 32'd0);
        chk("t5_rst_grant", 32'(grant_id), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        req_tdata[31:0] = 32'h3; cfg_nbits = 6'd1; req_tvalid = 4'b1001;
        #1;
        chk("t5_ready", 32'(req_tready), 32'h1);
        tick();
        req_tvalid = '0;
        chk("t5_grant", 32'(grant_id), 32'd0);
        recv("t5", 32'h3, 1, 1'b0);
        #1;
        chk("t5_count", 32'(frame_count), 32'd1);
        chk("t5_idle", 32'(bs.tvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piradip_bit_frame_scheduler.md
PIRADIP_BIT_FRAME_SCHEDULER -- requirements
Module: piradip_bit_frame_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of word requesters (2..16).
REQ-002 Parameter WIDTH, default 32, requester word width in bits.
REQ-003 Parameter GAP_W, default 8, width of the inter-frame gap counter.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cfg_nbits  input  $clog2(WIDTH+1)  bits per frame; 0 means WIDTH.
REQ-007 cfg_gap  input  GAP_W  idle cycles inserted after each frame.
REQ-008 req_tvalid  input  N_REQ  per-requester word valid.
REQ-009 req_tdata  input  N_REQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 req_tready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-011 bits_out  interface  piradip_bit_stream.MANAGER  serial output (tvalid, tdata, tlast; tready input).
REQ-012 grant_id  output  $clog2(N_REQ)  index of requester owning the current frame.
REQ-013 busy  output  1  high in SHIFT or GAP.
REQ-014 frame_count  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-015 FSM states IDLE, SHIFT, GAP; no other states.
REQ-016 IDLE: if any req_tvalid, the SHALL pick a winner round-robin, starting at (last_grant+1) mod N_REQ.
REQ-017 Acceptance: req_tready[winner] high for exactly that IDLE cycle, combinationally from req_tvalid; word, cfg_nbits, cfg_gap latched; next state SHIFT.
REQ-018 last_grant updates to the winner only on acceptance; reset value N_REQ-1, so requester 0 wins first.
REQ-019 Latency: bits_out.tvalid high in the cycle after acceptance.
REQ-020 Bit order: the low n latched bits, bit n-1 first, bit 0 last (n = latched nbits, 0->WIDTH); bits above n ignored.
REQ-021 SHIFT: tvalid=1; tdata and tlast stable until tvalid&tready; no tvalid drop mid-frame.
REQ-022 tlast high only with the last bit of a frame (n=1: the only bit).
REQ-023 Last bit accepted: frame_count increments; next state GAP if latched gap!=0, else IDLE.
REQ-024 GAP: tvalid=0 for exactly latched-gap cycles, then IDLE.
REQ-025 IDLE costs one cycle; minimum back-to-back frame spacing = one tvalid-low cycle.
REQ-026 cfg_* changes mid-frame SHALL NOT affect the frame in progress.
REQ-027 req_tready all zero outside IDLE; requester dropping tvalid while not granted is legal.
REQ-028 grant_id holds the last winner in all states.

Reset
REQ-029 On rst: state IDLE, bits_out.tvalid/tdata/tlast 0, req_tready 0, busy 0, grant_id 0, frame_count 0, last_grant N_REQ-1.
REQ-030 rst mid-frame SHALL abandon the frame without tlast, with tvalid low the following cycle; the partial frame is not counted.

Structure
REQ-031 Package piradip_bitsched_pkg SHALL hold the state enum and the frame_count width constant.
REQ-032 Round-robin selection SHALL be sub-module piradip_rr_arbiter (N_REQ param; request, last_grant in; one-hot grant, index out).
REQ-033 Serializer is inline (shift register plus $clog2(WIDTH+1) down-counter).

Verification
REQ-034 Single req0 word 0xA5, cfg_nbits=8, gap=0, tready=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after acceptance, tlast on 8th, frame_count=1.
REQ-035 All 4 requesters valid continuously, nbits=4 -> grants 0,1,2,3,0 in order, each frame 4 bits, one idle cycle between frames.
REQ-036 tready toggled 1,0,0,1,... during a 32-bit frame -> tdata/tlast stable while stalled, exactly 32 accepted bits, full word recovered.
REQ-037 cfg_gap=3, req1 back-to-back -> exactly 3 GAP cycles plus 1 IDLE cycle of tvalid=0 between frames; cfg_nbits changed mid-frame has no effect.
REQ-038 rst asserted after 5 bits of a 16-bit frame -> tvalid 0 next cycle, no tlast, frame_count 0; next grant goes to req0.
REQ-039 nbits=1 and cfg_nbits=0 (=WIDTH) frames -> single bit with tlast; WIDTH-bit frame respectively.
